mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 30 +++
 rtl/lsu_lane.sv | 53 +++++
 rtl/mem_lsu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared defines for the load/store unit: op encodings, bus widths and the bus timeout limit.
`ifndef MEM_LSU_DEFINES_SVH
`define MEM_LSU_DEFINES_SVH
`define AluOpBus 7:0
`define RegBus   31:0
`endif

package mem_lsu_pkg;

   localparam logic [7:0] ALU_OP_NOP  = 8'h00;
   localparam logic [7:0] ALU_OP_ADDU = 8'h21;
   localparam logic [7:0] ALU_OP_LB   = 8'he0;
   localparam logic [7:0] ALU_OP_LH   = 8'he1;
   localparam logic [7:0] ALU_OP_LW   = 8'he3;
   localparam logic [7:0] ALU_OP_SB   = 8'he8;
   localparam logic [7:0] ALU_OP_SH   = 8'he9;
   localparam logic [7:0] ALU_OP_SW   = 8'heb;

   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam int unsigned LSU_TIMEOUT = 255;

   function automatic logic is_load(input logic [7:0] op);
      return (op == ALU_OP_LB) || (op == ALU_OP_LH) || (op == ALU_OP_LW);
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: byte enables and store replication toward the bus,
// byte/halfword selection with sign extension for loads coming back.
module lsu_lane
   import mem_lsu_pkg::*;
(
   input  logic [`AluOpBus] op,
   input  logic [1:0]       addr_lo,
   input  logic [`RegBus]   sdata,
   input  logic [`RegBus]   rdata,
   output logic [3:0]       be,
   output logic             we,
   output logic [`RegBus]   wdata,
   output logic [`RegBus]   ldata
);

   function automatic logic signed [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic signed [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      be    = 4'b0000;
      we    = 1'b0;
      wdata = sdata;
      ldata = rdata;
      rbyte = rdata[{addr_lo, 3'b000} +: 8];
      rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         ALU_OP_SW: begin be = 4'b1111; we = 1'b1; end
         ALU_OP_SH: begin
            be    = 4'b0011 << {addr_lo[1], 1'b0};
            we    = 1'b1;
            wdata = {2{sdata[15:0]}};
         end
         ALU_OP_SB: begin
            be    = 4'b0001 << addr_lo;
            we    = 1'b1;
            wdata = {4{sdata[7:0]}};
         end
         ALU_OP_LW: be = 4'b1111;
         ALU_OP_LH: begin be = 4'b1111; ldata = sext16(rhalf); end
         ALU_OP_LB: begin be = 4'b1111; ldata = sext8(rbyte); end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: pass-through of ALU results, blocking data-bus access with timeout.
// Build option LSU_ALIGN_CHECK_EN rejects misaligned LW/LH/SH with a bus_err_o pulse instead of issuing them.
module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [`AluOpBus] aluop_i,
   input  logic [4:0]       wd_i,
   input  logic             wreg_i,
   input  logic [`RegBus]   wdata_i,
   input  logic [`RegBus]   mem_addr_i,
   input  logic [`RegBus]   reg2_i,
   output logic [4:0]       wd_o,
   output logic             wreg_o,
   output logic [`RegBus]   wdata_o,
   output logic             stallreq_o,
   output logic             d_req_o,
   output logic             d_we_o,
   output logic [3:0]       d_be_o,
   output logic [`RegBus]   d_addr_o,
   output logic [`RegBus]   d_wdata_o,
   input  logic [`RegBus]   d_rdata_i,
   input  logic             d_ack_i,
   output logic             bus_err_o
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [7:0] TMO_LAST = 8'(LSU_TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [7:0]       tmo_cnt;
   logic [`AluOpBus] op_p1;
   logic             wreg_p1;
   logic [4:0]       wd_p1;
   logic [`RegBus]   addr_p1, sdata_p1;
   logic             mem_op, misal, stall, take, done, abort, misal_err;
   logic [3:0]       lane_be;
   logic             lane_we;
   logic [`RegBus]   lane_wdata, lane_ldata;

   assign mem_op = is_load(aluop_i) | is_store(aluop_i);

`ifdef LSU_ALIGN_CHECK_EN
   assign misal = ((aluop_i == ALU_OP_LW) && (mem_addr_i[1:0] != 2'b00)) ||
                  (((aluop_i == ALU_OP_LH) || (aluop_i == ALU_OP_SH)) && mem_addr_i[0]);
`else
   assign misal = 1'b0;
`endif

   lsu_lane u_lane (
      .op      (op_p1),
      .addr_lo (addr_p1[1:0]),
      .sdata   (sdata_p1),
      .rdata   (d_rdata_i),
      .be      (lane_be),
      .we      (lane_we),
      .wdata   (lane_wdata),
      .ldata   (lane_ldata)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      take      = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      misal_err = 1'b0;
      d_req_o   = 1'b0;
      d_we_o    = 1'b0;
      d_be_o    = 4'b0000;
      d_addr_o  = ZeroWord;
      d_wdata_o = ZeroWord;
      case (state)
         IDLE: begin
            if (mem_op) begin
               if (misal) begin
                  misal_err = 1'b1;
               end else begin
                  stall     = 1'b1;
                  take      = 1'b1;
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            d_req_o   = 1'b1;
            d_we_o    = lane_we;
            d_be_o    = lane_be;
            d_addr_o  = {addr_p1[31:2], 2'b00};
            d_wdata_o = lane_wdata;
            if (d_ack_i) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stallreq_o = stall & ~rst;

   // Access capture: control fields reset, address/data only meaningful while in WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         op_p1   <= ALU_OP_NOP;
         wreg_p1 <= 1'b0;
      end else if (take) begin
         op_p1   <= aluop_i;
         wreg_p1 <= wreg_i;
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         wd_p1    <= wd_i;
         addr_p1  <= mem_addr_i;
         sdata_p1 <= reg2_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt   <= 8'd0;
         wd_o      <= 5'd0;
         wreg_o    <= 1'b0;
         wdata_o   <= ZeroWord;
         bus_err_o <= 1'b0;
      end else begin
         bus_err_o <= 1'b0;
         if (take)
            tmo_cnt <= 8'd0;
         else if ((state == WAIT) && !d_ack_i)
            tmo_cnt <= tmo_cnt + 8'd1;

         if (done) begin
            wd_o    <= wd_p1;
            wreg_o  <= wreg_p1 & is_load(op_p1);
            wdata_o <= is_load(op_p1) ? lane_ldata : ZeroWord;
         end else if (abort) begin
            wreg_o    <= 1'b0;
            wdata_o   <= ZeroWord;
            bus_err_o <= 1'b1;
         end else if (misal_err) begin
            wd_o      <= wd_i;
            wreg_o    <= 1'b0;
            wdata_o   <= ZeroWord;
            bus_err_o <= 1'b1;
         end else if ((state == IDLE) && !mem_op) begin
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= wdata_i;
         end else begin
            // bubble toward WB while the access is outstanding
            wreg_o <= 1'b0;
         end
      end
   end

endmodule
